// File: rtl/pwm_duty_ctrl.sv
// Pushbutton front end for the PWM generator: sync, debounce, press/auto-repeat
// stepping and clamped duty arithmetic, all in the clk domain.
module pwm_duty_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 500,
    parameter int unsigned REPEAT_RATE     = 100,
    parameter int unsigned STEP            = 5,
    parameter int unsigned DUTY_MAX        = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_n,
    input  logic       dec_n,
    output logic [7:0] duty,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       at_max,
    output logic       at_min
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] RD_LAST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RR_LAST = 16'(REPEAT_RATE - 1);
    localparam logic [7:0]  STEP8   = 8'(STEP);
    localparam logic [7:0]  DMAX8   = 8'(DUTY_MAX);
    localparam logic [8:0]  DMAX9   = 9'(DUTY_MAX);

    logic [1:0] btn_raw;
    logic [1:0] step_req;

    assign btn_raw = {dec_n, inc_n};

    // index 0 is the increment button, index 1 the decrement button
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic        sync1;
        logic        sync2;
        logic        stable;
        logic        stable_d;
        logic [15:0] db_cnt;
        logic [1:0]  state;
        logic [15:0] timer;
        logic        press;
        logic        rls;
        logic        req;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1    <= 1'b1;
                sync2    <= 1'b1;
                stable   <= 1'b1;
                stable_d <= 1'b1;
                db_cnt   <= '0;
            end else begin
                sync1    <= btn_raw[b];
                sync2    <= sync1;
                stable_d <= stable;
                // the edge that would bring the count to DEBOUNCE_CYCLES commits the level
                if (sync2 == stable) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    stable <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 16'd1;
                end
            end
        end

        assign press = stable_d & ~stable;
        assign rls   = ~stable_d & stable;

        // release wins over a coinciding repeat step
        always_comb begin
            req = 1'b0;
            case (state)
                IDLE:    req = press;
                DELAY:   req = ~rls && (timer == RD_LAST);
                REPEAT:  req = ~rls && (timer == RR_LAST);
                default: req = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (press) begin
                            state <= DELAY;
                            timer <= '0;
                        end
                    end
                    DELAY: begin
                        if (rls) begin
                            state <= IDLE;
                            timer <= '0;
                        end else if (timer == RD_LAST) begin
                            state <= REPEAT;
                            timer <= '0;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    REPEAT: begin
                        if (rls) begin
                            state <= IDLE;
                            timer <= '0;
                        end else if (timer == RR_LAST) begin
                            timer <= '0;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end

        assign step_req[b] = req;
    end

    logic [8:0] duty_sum;
    logic [7:0] duty_next;
    logic       inc_only;
    logic       dec_only;

    assign duty_sum = {1'b0, duty} + 9'(STEP);
    assign inc_only = (step_req == 2'b01);
    assign dec_only = (step_req == 2'b10);

    always_comb begin
        duty_next = duty;
        if (inc_only) begin
            duty_next = (duty_sum > DMAX9) ? DMAX8 : duty_sum[7:0];
        end else if (dec_only) begin
            duty_next = (duty < STEP8) ? 8'd0 : duty - STEP8;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty      <= '0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            at_max    <= 1'b0;
            at_min    <= 1'b1;
        end else begin
            duty      <= duty_next;
            inc_pulse <= inc_only && (duty_next != duty);
            dec_pulse <= dec_only && (duty_next != duty);
            at_max    <= (duty_next == DMAX8);
            at_min    <= (duty_next == 8'd0);
        end
    end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: scenario and random button stimulus compared each cycle
// against a timestamp-based reference of debounce, press/repeat schedule and clamping.
module tb_pwm_duty_ctrl;

    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RR   = 8;
    localparam int STEP = 5;
    localparam int DMAX = 50;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       inc_n = 1'b1;
    logic       dec_n = 1'b1;
    logic [7:0] duty;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       at_max;
    logic       at_min;

    int n_cmp = 0;
    int n_err = 0;

    pwm_duty_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .STEP           (STEP),
        .DUTY_MAX       (DMAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inc_n    (inc_n),
        .dec_n    (dec_n),
        .duty     (duty),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    always #5 clk = ~clk;

    // reference state: raw samples and debounced level per edge, press timestamps
    bit rawh [2][64];
    bit sh   [2][64];
    int pstart [2];
    int mduty;
    bit minc;
    bit mdec;
    int edge_no = 1000;

    int ipc;
    int dpc;
    int first_pulse_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 64; i++) begin
                rawh[b][i] = 1'b1;
                sh[b][i]   = 1'b1;
            end
            pstart[b] = -1;
        end
        mduty = 0;
        minc  = 1'b0;
        mdec  = 1'b0;
    endtask

    task automatic model_edge(input bit r0, input bit r1);
        bit req [2];
        bit s1;
        bit s2;
        bit flip;
        int n;
        int old;
        edge_no++;
        n = edge_no;
        for (int b = 0; b < 2; b++) begin
            rawh[b][n % 64] = (b == 0) ? r0 : r1;
            s1 = sh[b][(n - 1) % 64];
            s2 = sh[b][(n - 2) % 64];
            req[b] = 1'b0;
            if (s2 && !s1) begin
                req[b]    = 1'b1;
                pstart[b] = n;
            end else if (!s2 && s1) begin
                pstart[b] = -1;
            end else if (pstart[b] >= 0 && n - pstart[b] >= RD &&
                         (n - pstart[b] - RD) % RR == 0) begin
                req[b] = 1'b1;
            end
            // level accepted once the D samples ending two edges back all disagree
            flip = 1'b1;
            for (int k = n - D - 1; k <= n - 2; k++) begin
                if (rawh[b][k % 64] == s1) flip = 1'b0;
            end
            sh[b][n % 64] = flip ? !s1 : s1;
        end
        old  = mduty;
        minc = 1'b0;
        mdec = 1'b0;
        if (req[0] && !req[1]) begin
            mduty = (old + STEP > DMAX) ? DMAX : old + STEP;
            minc  = (mduty != old);
        end else if (req[1] && !req[0]) begin
            mduty = (old < STEP) ? 0 : old - STEP;
            mdec  = (mduty != old);
        end
    endtask

    task automatic check_outputs();
        chk("duty", 32'(duty), 32'(mduty));
        chk("inc_pulse", 32'(inc_pulse), 32'(minc));
        chk("dec_pulse", 32'(dec_pulse), 32'(mdec));
        chk("at_max", 32'(at_max), 32'(mduty == DMAX));
        chk("at_min", 32'(at_min), 32'(mduty == 0));
    endtask

    task automatic tick();
        bit r0;
        bit r1;
        @(posedge clk);
        r0 = inc_n;
        r1 = dec_n;
        if (reset) model_edge(r0, r1);
        #1;
        check_outputs();
        if (inc_pulse === 1'b1) begin
            ipc++;
            if (first_pulse_edge < 0) first_pulse_edge = edge_no;
        end
        if (dec_pulse === 1'b1) dpc++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic clear_counts();
        ipc = 0;
        dpc = 0;
        first_pulse_edge = -1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        run(3);
        reset = 1'b1;
    endtask

    initial begin
        int e0;
        int d0;
        int rem [2];
        model_reset();
        clear_counts();

        // reset state
        run(3);
        reset = 1'b1;
        run(2);

        // single clean press with latency check
        clear_counts();
        inc_n = 1'b0;
        e0 = edge_no + 1;
        run(10);
        inc_n = 1'b1;
        run(15);
        chk("single_pulses", 32'(ipc), 32'd1);
        chk("single_latency", 32'(first_pulse_edge - e0), 32'd6);
        chk("single_duty", 32'(duty), 32'd5);

        // bounce shorter than the debounce window
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            inc_n = 1'b0;
            run(2);
            inc_n = 1'b1;
            run(2);
        end
        run(10);
        chk("bounce_pulses", 32'(ipc + dpc), 32'd0);
        chk("bounce_duty", 32'(duty), 32'd5);

        // auto-repeat up to the clamp from zero
        do_reset();
        clear_counts();
        inc_n = 1'b0;
        run(200);
        chk("repeat_pulses", 32'(ipc), 32'd10);
        chk("repeat_duty", 32'(duty), 32'd50);
        chk("repeat_at_max", 32'(at_max), 32'd1);
        inc_n = 1'b1;
        run(20);

        // decrement down to 5, then two presses against the floor
        while (mduty > 5) begin
            dec_n = 1'b0;
            run(8);
            dec_n = 1'b1;
            run(10);
        end
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            dec_n = 1'b0;
            run(8);
            dec_n = 1'b1;
            run(10);
        end
        chk("floor_pulses", 32'(dpc), 32'd1);
        chk("floor_duty", 32'(duty), 32'd0);
        chk("floor_at_min", 32'(at_min), 32'd1);

        // simultaneous presses cancel, including their repeats
        inc_n = 1'b0;
        run(8);
        inc_n = 1'b1;
        run(10);
        d0 = mduty;
        clear_counts();
        inc_n = 1'b0;
        dec_n = 1'b0;
        run(60);
        inc_n = 1'b1;
        dec_n = 1'b1;
        run(20);
        chk("both_pulses", 32'(ipc + dpc), 32'd0);
        chk("both_duty", 32'(duty), 32'(d0));

        // reset while held in REPEAT, button still down afterwards
        inc_n = 1'b0;
        run(40);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("midhold_reset_duty", 32'(duty), 32'd0);
        run(3);
        reset = 1'b1;
        clear_counts();
        e0 = edge_no + 1;
        run(50);
        chk("after_reset_latency", 32'(first_pulse_edge - e0), 32'd6);
        chk("after_reset_pulses", 32'(ipc), 32'd4);
        inc_n = 1'b1;
        run(20);

        // random button activity: bounces and holds of mixed length
        rem[0] = 0;
        rem[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rem[0] == 0) begin
                inc_n  = ($urandom_range(0, 2) == 0) ? 1'b0 : ~inc_n;
                rem[0] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6)
                                                      : $urandom_range(10, 90);
            end
            if (rem[1] == 0) begin
                dec_n  = ($urandom_range(0, 2) == 0) ? 1'b0 : ~dec_n;
                rem[1] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6)
                                                      : $urandom_range(10, 90);
            end
            rem[0]--;
            rem[1]--;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
